// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pc_state_e;

   localparam int PC_D_DEFAULT     = 12;
   localparam int PC_START_DEFAULT = 0;
   localparam int BRCNT_W          = 16;

endpackage

// File: rtl/pc_seq_if.sv
// Host-side bundle of the sequencer: control inputs and PC/status outputs.
// br_cnt exists only when PC_BRCNT_EN is defined.
interface pc_seq_if #(
   parameter int D = pc_pkg::PC_D_DEFAULT
);
   logic         req;
   logic         stall;
   logic         branch_en;
   logic [D-1:0] target;
   logic         halt;
   logic [D-1:0] prog_ctr;
   logic         running;
   logic         done;
   logic         timeout;
`ifdef PC_BRCNT_EN
   logic [15:0]  br_cnt;

   modport master (
      output req, stall, branch_en, target, halt,
      input  prog_ctr, running, done, timeout, br_cnt
   );
   modport slave (
      input  req, stall, branch_en, target, halt,
      output prog_ctr, running, done, timeout, br_cnt
   );
`else
   modport master (
      output req, stall, branch_en, target, halt,
      input  prog_ctr, running, done, timeout
   );
   modport slave (
      input  req, stall, branch_en, target, halt,
      output prog_ctr, running, done, timeout
   );
`endif
endinterface

// File: rtl/br_perf_ctr.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module br_perf_ctr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: IDLE/RUN/DONE with stall, relative branch, halt and watchdog.
// Optional taken-branch counter enabled by macro PC_BRCNT_EN.
module pc_seq
   import pc_pkg::*;
#(
   parameter int D          = PC_D_DEFAULT,
   parameter int START_ADDR = PC_START_DEFAULT,
   parameter int MAX_CYCLES = 4095
) (
   input  logic     clk,
   input  logic     reset_n,
   pc_seq_if.slave  bus
);
   localparam logic [D-1:0] START_PC = D'(START_ADDR);
   // Expiry fires on the RUN cycle that brings the count up to MAX_CYCLES.
   localparam logic [D-1:0] WD_LAST  = D'(MAX_CYCLES - 1);

   pc_state_e    state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic [D-1:0] cyc_q, cyc_d;
   logic         done_q, done_d;
   logic         timeout_q, timeout_d;
   logic         wd_expire;

   assign wd_expire = (cyc_q == WD_LAST);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cyc_d     = cyc_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.req) begin
               state_d   = ST_RUN;
               pc_d      = START_PC;
               cyc_d     = '0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (cyc_q != '1) begin
               cyc_d = cyc_q + 1'b1;
            end
            if (bus.halt) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               if (!bus.stall) begin
                  pc_d = bus.branch_en ? (pc_q + bus.target) : (pc_q + 1'b1);
               end
               if (wd_expire) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= START_PC;
         cyc_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cyc_q     <= cyc_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.prog_ctr = pc_q;
   assign bus.running  = (state_q == ST_RUN);
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;

`ifdef PC_BRCNT_EN
   logic br_clr, br_inc;

   assign br_clr = (state_q != ST_RUN) && bus.req;
   assign br_inc = (state_q == ST_RUN) && bus.branch_en && !bus.stall && !bus.halt;

   br_perf_ctr #(
      .W (BRCNT_W)
   ) u_br_perf_ctr (
      .clk   (clk),
      .rst_n (reset_n),
      .clr_i (br_clr),
      .inc_i (br_inc),
      .cnt_o (bus.br_cnt)
   );
`endif
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (D=12, START_ADDR=0, MAX_CYCLES=10); inputs driven and outputs sampled at negedge.
module tb_pc_seq;
   import pc_pkg::*;

   logic clk;
   logic reset_n;
   int   tests;
   int   failed;

   pc_seq_if #(.D(12)) bus ();

   pc_seq #(
      .D          (12),
      .START_ADDR (0),
      .MAX_CYCLES (10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) $display("[TB] ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset_n       = 1'b1;
      bus.req       = 1'b0;
      bus.stall     = 1'b0;
      bus.branch_en = 1'b0;
      bus.target    = 12'h000;
      bus.halt      = 1'b0;

      // Asynchronous reset before any clock edge
      #1 reset_n = 1'b0;
      #1;
      chk("rst_pc",      32'(bus.prog_ctr), 32'h000);
      chk("rst_running", 32'(bus.running),  32'h0);
      chk("rst_done",    32'(bus.done),     32'h0);
      chk("rst_timeout", 32'(bus.timeout),  32'h0);
`ifdef PC_BRCNT_EN
      chk("rst_brcnt",   32'(bus.br_cnt),   32'h0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      step();
      chk("idle_running", 32'(bus.running), 32'h0);

      // Start and sequential fetch
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      chk("run_entry",   32'(bus.running),  32'h1);
      chk("seq_pc0",     32'(bus.prog_ctr), 32'h000);
      step(); chk("seq_pc1", 32'(bus.prog_ctr), 32'h001);
      step(); chk("seq_pc2", 32'(bus.prog_ctr), 32'h002);
      step(); chk("seq_pc3", 32'(bus.prog_ctr), 32'h003);
      chk("seq_running", 32'(bus.running),  32'h1);
      step(); chk("seq_pc4", 32'(bus.prog_ctr), 32'h004);

      // Relative branches: negative then positive offset
      bus.branch_en = 1'b1;
      bus.target    = 12'hFFB;
      step(); chk("br_neg", 32'(bus.prog_ctr), 32'hFFF);
      bus.target    = 12'd20;
      step(); chk("br_pos", 32'(bus.prog_ctr), 32'h013);
      bus.branch_en = 1'b0;

      // req during RUN has no effect
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      chk("req_in_run", 32'(bus.prog_ctr), 32'h014);

      // Stall holds PC and suppresses the branch
      bus.stall     = 1'b1;
      bus.branch_en = 1'b1;
      bus.target    = 12'h005;
      step(); chk("stall_hold", 32'(bus.prog_ctr), 32'h014);
      bus.stall     = 1'b0;
      bus.branch_en = 1'b0;

      // Watchdog: tenth RUN cycle ends the program with timeout
      step();
      chk("wd_pre_pc",   32'(bus.prog_ctr), 32'h015);
      chk("wd_pre_done", 32'(bus.done),     32'h0);
      step();
      chk("wd_done",     32'(bus.done),     32'h1);
      chk("wd_timeout",  32'(bus.timeout),  32'h1);
      chk("wd_running",  32'(bus.running),  32'h0);
      chk("wd_pc",       32'(bus.prog_ctr), 32'h016);
      step(); step();
      chk("done_hold_pc", 32'(bus.prog_ctr), 32'h016);
      chk("done_hold_to", 32'(bus.timeout),  32'h1);

      // Restart from DONE
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      chk("restart_pc",   32'(bus.prog_ctr), 32'h000);
      chk("restart_done", 32'(bus.done),     32'h0);
      chk("restart_to",   32'(bus.timeout),  32'h0);
      chk("restart_run",  32'(bus.running),  32'h1);

      // Wrap at 2^D-1
      bus.branch_en = 1'b1;
      bus.target    = 12'hFFF;
      step(); chk("wrap_pre", 32'(bus.prog_ctr), 32'hFFF);
      bus.branch_en = 1'b0;
      step(); chk("wrap_zero", 32'(bus.prog_ctr), 32'h000);

      // Advance to PC 7 (also the watchdog's final cycle): halt beats branch and watchdog
      for (int i = 0; i < 7; i++) step();
      chk("pre_halt_pc", 32'(bus.prog_ctr), 32'h007);
      bus.halt      = 1'b1;
      bus.branch_en = 1'b1;
      bus.target    = 12'h003;
      step();
      bus.halt      = 1'b0;
      bus.branch_en = 1'b0;
      chk("halt_pc",      32'(bus.prog_ctr), 32'h007);
      chk("halt_done",    32'(bus.done),     32'h1);
      chk("halt_timeout", 32'(bus.timeout),  32'h0);
      chk("halt_running", 32'(bus.running),  32'h0);

      // Reset between edges while running
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      step(); step();
      chk("mid_pc", 32'(bus.prog_ctr), 32'h002);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_pc",      32'(bus.prog_ctr), 32'h000);
      chk("arst_running", 32'(bus.running),  32'h0);
      chk("arst_done",    32'(bus.done),     32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      chk("post_rst_run",  32'(bus.running), 32'h0);
      chk("post_rst_done", 32'(bus.done),    32'h0);

`ifdef PC_BRCNT_EN
      // Three taken branches and one stalled branch
      bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      chk("brc_clear", 32'(bus.br_cnt), 32'h0);
      bus.branch_en = 1'b1;
      bus.target    = 12'h002;
      step();
      step();
      bus.stall = 1'b1;
      step();
      bus.stall = 1'b0;
      step();
      bus.branch_en = 1'b0;
      chk("brc_pc",    32'(bus.prog_ctr), 32'h006);
      chk("brc_count", 32'(bus.br_cnt),   32'h3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
